// File: rtl/nubus.sv
// ----------------------------------------------------------------------------
// nubus -- NuBus slave-only bridge to a simple memory request port.
//
// Responds to slot space {4'hF, ID} (and optionally super space) with a
// single-word memory access and a one-clock acknowledge. The master port is
// tied off with cpu_ready and cpu_rdata held at 0. No arbitration is performed.
//
// Timing: NuBus signals change on the rising edge of nub_clkn and are
// sampled on the falling edge. The FSM, all captures and reset live on the
// falling edge; the acknowledge drive enable is launched on the rising edge
// so the bus is driven for exactly one full clock.
//
// Build option:
//   NUBUS_SUPER_EN  when defined, super space A[31:28] = ID (ID 1..E) is
//                   also decoded and flagged on mem_super. When undefined,
//                   super space is ignored and mem_super is tied to 0.
//
// Ports:
//   nub_clkn, nub_reset   NuBus clock, synchronous active-high reset
//   nub_idn               inverted slot ID
//   nub_pfwn              power-fail warning (ignored)
//   nub_adn               inverted address/data, driven only for read ACK
//   nub_tm0n, nub_tm1n    inverted transfer mode in / status out
//   nub_startn, nub_ackn  cycle start in / acknowledge out
//   nub_rqstn, nub_arbn, nub_nmrqn, nub_spn, nub_spvn  never driven
//   mem_*                 memory request/response port (word addressed)
//   cpu_*                 master port (cpu_ready/cpu_rdata held at 0)
// ----------------------------------------------------------------------------
// state  | meaning
// IDLE   | waiting for START with an address hit
// ADDR   | address latched; write data captured on this falling edge
// MEM    | mem_valid held until mem_ready is sampled high
// ACK    | ACK/status (and read data) driven for one clock
// ----------------------------------------------------------------------------
module nubus (
    input  logic        nub_clkn,
    input  logic        nub_reset,
    input  logic [3:0]  nub_idn,
    input  logic        nub_pfwn,
    inout  wire  [31:0] nub_adn,
    inout  wire         nub_tm0n,
    inout  wire         nub_tm1n,
    input  logic        nub_startn,
    inout  wire         nub_ackn,
    inout  wire         nub_rqstn,
    inout  wire  [3:0]  nub_arbn,
    inout  wire         nub_nmrqn,
    inout  wire         nub_spn,
    inout  wire         nub_spvn,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [3:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_slot,
    output logic        mem_super,

    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_write,
    input  logic        cpu_lock,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_MEM  = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic        r_write;
    logic        r_block;
    logic [3:0]  r_lanes;
    logic        r_slot;
    logic        r_super;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_drv;

    // Logical (active-high) views of the inverted bus pins.
    logic [31:0] w_ad;
    logic        w_tm1;
    logic        w_tm0;
    logic        w_start;
    logic [3:0]  w_id;
    logic        w_slot_hit;
    logic        w_super_hit;
    logic        w_hit;
    logic [3:0]  w_lanes;
    logic        w_drv;
    logic        w_unused;

    assign w_ad    = ~nub_adn;
    assign w_tm1   = ~nub_tm1n;
    assign w_tm0   = ~nub_tm0n;
    assign w_start = ~nub_startn;
    assign w_id    = ~nub_idn;

    assign w_slot_hit = (w_ad[31:24] == {4'hF, w_id});

`ifdef NUBUS_SUPER_EN
    // IDs 0 and F have no super space of their own.
    assign w_super_hit = (w_ad[31:28] == w_id) && (w_id != 4'h0) && (w_id != 4'hF);
`else
    assign w_super_hit = 1'b0;
`endif

    assign w_hit = w_slot_hit || w_super_hit;

    // Byte lanes from {/TM0, /AD1, /AD0}; 011 is block mode and moves no data.
    function automatic logic [3:0] f_lanes(input logic [2:0] i_mode);
        logic [3:0] v;
        case (i_mode)
            3'b000:  v = 4'b1000;
            3'b001:  v = 4'b1100;
            3'b010:  v = 4'b0100;
            3'b011:  v = 4'b0000;
            3'b100:  v = 4'b0010;
            3'b101:  v = 4'b0011;
            3'b110:  v = 4'b0001;
            default: v = 4'b1111;
        endcase
        return v;
    endfunction

    assign w_lanes = f_lanes({w_tm0, w_ad[1:0]});

    // Next-state logic; START outside IDLE is ignored by construction.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start && w_hit) w_next = S_ADDR;
            S_ADDR: w_next = r_block ? S_ACK : S_MEM;
            S_MEM:  if (mem_ready) w_next = S_ACK;
            S_ACK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(negedge nub_clkn) begin
        if (nub_reset) begin
            r_state <= S_IDLE;
            r_addr  <= 32'h0;
            r_write <= 1'b0;
            r_block <= 1'b0;
            r_lanes <= 4'h0;
            r_slot  <= 1'b0;
            r_super <= 1'b0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_start && w_hit) begin
                r_addr  <= {w_ad[31:2], 2'b00};
                r_write <= ~w_tm1;
                r_block <= ({w_tm0, w_ad[1:0]} == 3'b011);
                r_lanes <= w_lanes;
                r_slot  <= w_slot_hit;
                r_super <= w_super_hit && !w_slot_hit;
            end
            if (r_state == S_ADDR && r_write && !r_block) begin
                r_wdata <= w_ad;
            end
            if (r_state == S_MEM && mem_ready) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Drive enable launched on the rising edge after ACK is entered and
    // dropped on the next rising edge, once the FSM has returned to IDLE.
    always_ff @(posedge nub_clkn) begin
        if (nub_reset) begin
            r_drv <= 1'b0;
        end else begin
            r_drv <= (r_state == S_ACK);
        end
    end

    // Reset releases the bus immediately, even in the middle of an ACK clock.
    assign w_drv = r_drv && !nub_reset;

    // Status: /TM1=1 always; /TM0=1 complete, /TM0=0 error (block mode).
    assign nub_ackn = w_drv ? 1'b0 : 1'bz;
    assign nub_tm1n = w_drv ? 1'b0 : 1'bz;
    assign nub_tm0n = w_drv ? r_block : 1'bz;
    assign nub_adn  = (w_drv && !r_write && !r_block) ? ~r_rdata : {32{1'bz}};

    assign nub_rqstn = 1'bz;
    assign nub_arbn  = 4'bzzzz;
    assign nub_nmrqn = 1'bz;
    assign nub_spn   = 1'bz;
    assign nub_spvn  = 1'bz;

    assign mem_valid = (r_state == S_MEM);
    assign mem_write = (mem_valid && r_write) ? r_lanes : 4'h0;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_slot  = mem_valid && r_slot;
    assign mem_super = mem_valid && r_super;

    assign cpu_ready = 1'b0;
    assign cpu_rdata = 32'h0;

    assign w_unused = ^{nub_pfwn, nub_rqstn, nub_arbn, nub_nmrqn, nub_spn, nub_spvn,
                        cpu_valid, cpu_addr, cpu_wdata, cpu_write, cpu_lock};

endmodule

// File: tb/tb_nubus.sv
module tb_nubus;

    logic        clk;
    logic        rst;
    logic [3:0]  idn;
    logic        startn;

    tri1 [31:0]  adn;
    tri1         tm0n;
    tri1         tm1n;
    tri1         ackn;
    tri1         rqstn;
    tri1 [3:0]   arbn;
    tri1         nmrqn;
    tri1         spn;
    tri1         spvn;

    logic        m_adn_oe;
    logic [31:0] m_adn;
    logic        m_tm_oe;
    logic        m_tm0n;
    logic        m_tm1n;

    assign adn  = m_adn_oe ? m_adn : {32{1'bz}};
    assign tm0n = m_tm_oe ? m_tm0n : 1'bz;
    assign tm1n = m_tm_oe ? m_tm1n : 1'bz;

    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_slot;
    logic        mem_super;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;

    nubus dut (
        .nub_clkn   (clk),
        .nub_reset  (rst),
        .nub_idn    (idn),
        .nub_pfwn   (1'b1),
        .nub_adn    (adn),
        .nub_tm0n   (tm0n),
        .nub_tm1n   (tm1n),
        .nub_startn (startn),
        .nub_ackn   (ackn),
        .nub_rqstn  (rqstn),
        .nub_arbn   (arbn),
        .nub_nmrqn  (nmrqn),
        .nub_spn    (spn),
        .nub_spvn   (spvn),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_slot   (mem_slot),
        .mem_super  (mem_super),
        .cpu_valid  (1'b0),
        .cpu_addr   (32'h0),
        .cpu_wdata  (32'h0),
        .cpu_write  (4'h0),
        .cpu_lock   (1'b0),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Memory model: zeroed, 16 words, byte-enable writes, programmable wait.
    logic [31:0] mem [16];
    int          mem_wait = 0;

    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid && !mem_ready) begin
                if (wcnt >= mem_wait) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_write[b]) mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_rdata = mem[mem_addr[5:2]];
                    mem_ready = 1'b1;
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end
        end
    end

    typedef struct {
        bit          acked;
        bit          ack_one;
        logic [1:0]  tm;
        logic [31:0] rd;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          valid;
        bit          slot;
        bit          sup;
        int          lat;
    } res_t;

    // Master start: address clock then data clock; mode = {/TM0,/AD1,/AD0}.
    task automatic drive_start(input logic [31:0] a, input bit wr, input logic [2:0] mode,
                               input logic [31:0] wd);
        @(posedge clk);
        #1;
        startn   = 1'b0;
        m_adn_oe = 1'b1;
        m_adn    = ~{a[31:2], mode[1:0]};
        m_tm_oe  = 1'b1;
        m_tm1n   = wr ? 1'b1 : 1'b0;
        m_tm0n   = ~mode[2];
        @(posedge clk);
        #1;
        startn  = 1'b1;
        m_tm_oe = 1'b0;
        if (wr) m_adn = ~wd;
        else    m_adn_oe = 1'b0;
    endtask

    task automatic bus_cycle(input logic [31:0] a, input bit wr, input logic [2:0] mode,
                             input logic [31:0] wd, output res_t r);
        int rdy_i;
        r       = '{default: '0};
        r.lat   = -1;
        rdy_i   = -100;
        drive_start(a, wr, mode, wd);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #2;
            if (mem_valid) begin
                r.valid = 1'b1;
                r.we    = r.we | mem_write;
                r.addr  = mem_addr;
                r.wdata = mem_wdata;
                r.slot  = r.slot | mem_slot;
                r.sup   = r.sup | mem_super;
            end
            if (mem_ready) rdy_i = i;
            if (ackn === 1'b0) begin
                r.acked = 1'b1;
                r.tm    = {~tm1n, ~tm0n};
                r.rd    = ~adn;
                r.lat   = i - rdy_i;
                break;
            end
        end
        if (r.acked) begin
            @(negedge clk);
            #2;
            r.ack_one = (ackn === 1'b1);
        end
        @(posedge clk);
        #1;
        m_adn_oe = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        logic [31:0] a;
        bit          wr;
        logic [2:0]  mode;
        logic [31:0] wd;
        int          wt;
        bit          e_ack;
        logic [1:0]  e_tm;
        bit          chk_rd;
        logic [31:0] e_rd;
        logic [3:0]  e_we;
        bit          e_valid;
    } vec_t;

    vec_t vecs [16];

    initial begin
        res_t r;
        int   nv;

        rst      = 1'b1;
        idn      = 4'hF;          // ID 0
        startn   = 1'b1;
        m_adn_oe = 1'b0;
        m_adn    = 32'h0;
        m_tm_oe  = 1'b0;
        m_tm0n   = 1'b1;
        m_tm1n   = 1'b1;

        //            addr          wr mode    wdata         wt ack tm     rd? rd            we     valid
        vecs[0]  = '{32'hF0000000, 1, 3'b111, 32'h87654321, 0, 1, 2'b11, 0, 32'h0,        4'hF,  1};
        vecs[1]  = '{32'hF0000000, 0, 3'b111, 32'h0,        0, 1, 2'b11, 1, 32'h87654321, 4'h0,  1};
        vecs[2]  = '{32'hF0000004, 1, 3'b101, 32'h87654321, 0, 1, 2'b11, 0, 32'h0,        4'h3,  1};
        vecs[3]  = '{32'hF0000004, 0, 3'b101, 32'h0,        0, 1, 2'b11, 1, 32'h00004321, 4'h0,  1};
        vecs[4]  = '{32'hF0000018, 1, 3'b000, 32'h87654321, 0, 1, 2'b11, 0, 32'h0,        4'h8,  1};
        vecs[5]  = '{32'hF0000018, 0, 3'b000, 32'h0,        0, 1, 2'b11, 1, 32'h87000000, 4'h0,  1};
        vecs[6]  = '{32'hF000000C, 1, 3'b100, 32'hAABBCCDD, 0, 1, 2'b11, 0, 32'h0,        4'h2,  1};
        vecs[7]  = '{32'hF000000C, 1, 3'b010, 32'h11223344, 1, 1, 2'b11, 0, 32'h0,        4'h4,  1};
        vecs[8]  = '{32'hF000000C, 0, 3'b111, 32'h0,        0, 1, 2'b11, 1, 32'h0022CC00, 4'h0,  1};
        vecs[9]  = '{32'hF1000000, 1, 3'b111, 32'h12345678, 0, 0, 2'b00, 0, 32'h0,        4'h0,  0};
        vecs[10] = '{32'hF0000008, 0, 3'b011, 32'h0,        0, 1, 2'b10, 0, 32'h0,        4'h0,  0};
        vecs[11] = '{32'hF0000000, 0, 3'b111, 32'h0,        2, 1, 2'b11, 1, 32'h87654321, 4'h0,  1};
        vecs[12] = '{32'hF0000010, 1, 3'b001, 32'h87654321, 0, 1, 2'b11, 0, 32'h0,        4'hC,  1};
        vecs[13] = '{32'hF0000010, 0, 3'b110, 32'h0,        0, 1, 2'b11, 1, 32'h87650000, 4'h0,  1};
        vecs[14] = '{32'h90000000, 0, 3'b111, 32'h0,        0, 0, 2'b00, 0, 32'h0,        4'h0,  0};
        vecs[15] = '{32'hF0000014, 1, 3'b110, 32'h000000A5, 0, 1, 2'b11, 0, 32'h0,        4'h1,  1};
        nv = 16;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_mem_write", {28'h0, mem_write}, 32'h0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_slot",  {31'h0, mem_slot}, 32'h0);
        chk("rst_mem_super", {31'h0, mem_super}, 32'h0);
        chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ackn",      {31'h0, ackn}, 32'h1);

        for (int i = 0; i < nv; i++) begin
            mem_wait = vecs[i].wt;
            bus_cycle(vecs[i].a, vecs[i].wr, vecs[i].mode, vecs[i].wd, r);
            chk($sformatf("v%0d_ack", i),   {31'h0, r.acked}, {31'h0, vecs[i].e_ack});
            chk($sformatf("v%0d_valid", i), {31'h0, r.valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_we", i),    {28'h0, r.we},    {28'h0, vecs[i].e_we});
            if (vecs[i].e_ack) begin
                chk($sformatf("v%0d_tm", i),      {30'h0, r.tm},      {30'h0, vecs[i].e_tm});
                chk($sformatf("v%0d_ack_len", i), {31'h0, r.ack_one}, 32'h1);
            end
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_addr", i), r.addr, {vecs[i].a[31:2], 2'b00});
                chk($sformatf("v%0d_slot", i), {31'h0, r.slot}, 32'h1);
                chk($sformatf("v%0d_super", i), {31'h0, r.sup}, 32'h0);
                if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), r.wdata, vecs[i].wd);
            end
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), r.rd, vecs[i].e_rd);
        end

        // Three-clock memory wait: ACK follows mem_ready by exactly one clock.
        mem_wait = 3;
        bus_cycle(32'hF0000000, 0, 3'b111, 32'h0, r);
        chk("wait3_ack",   {31'h0, r.acked}, 32'h1);
        chk("wait3_lat",   r.lat, 32'h1);
        chk("wait3_len",   {31'h0, r.ack_one}, 32'h1);
        chk("wait3_rdata", r.rd, 32'h87654321);
        mem_wait = 0;

        // Reset asserted while the memory is still busy: cycle is aborted.
        begin
            bit saw_valid;
            bit saw_ack;
            bit post_valid;
            mem_wait  = 10;
            saw_valid = 1'b0;
            saw_ack   = 1'b0;
            post_valid = 1'b0;
            drive_start(32'hF0000000, 0, 3'b111, 32'h0);
            for (int i = 0; i < 6 && !saw_valid; i++) begin
                @(negedge clk);
                #2;
                saw_valid = mem_valid;
            end
            chk("rstmid_in_mem", {31'h0, saw_valid}, 32'h1);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(negedge clk);
            #2;
            chk("rstmid_valid", {31'h0, mem_valid}, 32'h0);
            chk("rstmid_ackn_z", {31'h0, ackn}, 32'h1);
            @(posedge clk);
            #1;
            rst = 1'b0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                #2;
                if (ackn === 1'b0) saw_ack = 1'b1;
                if (mem_valid) post_valid = 1'b1;
            end
            chk("rstmid_no_ack", {31'h0, saw_ack}, 32'h0);
            chk("rstmid_idle", {31'h0, post_valid}, 32'h0);
            chk("rstmid_addr", mem_addr, 32'h0);
            mem_wait = 0;
        end

        // Super space with ID 9.
        idn = ~4'h9;
        bus_cycle(32'h90000000, 0, 3'b111, 32'h0, r);
`ifdef NUBUS_SUPER_EN
        chk("super_ack",   {31'h0, r.acked}, 32'h1);
        chk("super_flag",  {31'h0, r.sup},   32'h1);
        chk("super_slot",  {31'h0, r.slot},  32'h0);
        chk("super_rdata", r.rd, 32'h87654321);
`else
        chk("super_ack",   {31'h0, r.acked}, 32'h0);
        chk("super_valid", {31'h0, r.valid}, 32'h0);
        chk("super_flag",  {31'h0, r.sup},   32'h0);
`endif

        // Slot decode follows the ID pins: ID 3 owns F3, no longer F0.
        idn = ~4'h3;
        bus_cycle(32'hF3000004, 1, 3'b111, 32'hDEADBEEF, r);
        chk("id3_ack",  {31'h0, r.acked}, 32'h1);
        chk("id3_we",   {28'h0, r.we}, 32'hF);
        bus_cycle(32'hF3000004, 0, 3'b111, 32'h0, r);
        chk("id3_rdata", r.rd, 32'hDEADBEEF);
        bus_cycle(32'hF0000004, 0, 3'b111, 32'h0, r);
        chk("id3_f0_miss", {31'h0, r.acked}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nubus.md
NUBUS -- requirements
Module: nubus

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: nub_clkn in 1 (NuBus clock; rising edge drives, falling edge samples); nub_reset in 1 (synchronous, active-high, sampled on nub_clkn falling edge).
REQ-002 The block SHALL have no parameters.
REQ-003 The NuBus ports SHALL be:
- nub_idn in 4: inverted slot ID.
- nub_pfwn in 1: power-fail warning, ignored.
- nub_adn inout 32: inverted address/data.
- nub_tm0n, nub_tm1n inout 1 each: inverted transfer mode/status.
- nub_startn in 1: cycle start.
- nub_ackn inout 1: acknowledge.
- nub_rqstn, nub_arbn[3:0], nub_nmrqn, nub_spn, nub_spvn inout: never driven.
REQ-004 The memory-side ports SHALL be:
- mem_valid out 1: request.
- mem_ready in 1: done.
- mem_write out 4: byte enables.
- mem_addr out 32: word address.
- mem_wdata out 32: write data.
- mem_rdata in 32: read data.
- mem_slot out 1: slot-space hit.
- mem_super out 1: super-space hit.
REQ-005 The master ports SHALL be: cpu_valid in 1; cpu_addr in 32; cpu_wdata in 32; cpu_write in 4; cpu_lock in 1; cpu_ready out 1; cpu_rdata out 32.

Function
REQ-006 The block SHALL invert all bus signals internally: logical value = ~pin.
REQ-007 The block SHALL drive every bus output open (Z) except during its own acknowledge cycle.
REQ-008 On a falling edge with nub_startn=0 in IDLE, the block SHALL latch A=~nub_adn and the mode bits /TM1,/TM0,/AD1,/AD0.
REQ-009 The block SHALL decode a slot-space hit when A[31:24] = {4'hF, ~nub_idn}.
REQ-010 /TM1=0 SHALL mean write and /TM1=1 SHALL mean read.
REQ-011 Byte lanes SHALL decode from {/TM0,/AD1,/AD0}:
- 000 byte3 -> 1000; 001 half1 -> 1100; 010 byte2 -> 0100; 011 block.
- 100 byte1 -> 0010; 101 half0 -> 0011; 110 byte0 -> 0001; 111 word -> 1111.
REQ-012 The state machine SHALL be IDLE -> (hit) ADDR -> MEM -> ACK -> IDLE; a miss SHALL stay in IDLE.
REQ-013 ADDR SHALL last one clock; for writes it SHALL capture mem_wdata=~nub_adn on the next falling edge.
REQ-014 In MEM the block SHALL hold mem_valid=1, mem_addr={A[31:2],2'b00}, mem_write=lanes (0000 for reads), and mem_slot/mem_super until mem_ready is sampled 1; there is no timeout.
REQ-015 In ACK the block SHALL, for exactly one clock starting on a rising edge, drive nub_ackn=0 and /TM1=/TM0=1 (complete); for reads it SHALL also drive nub_adn=~mem_rdata (full word, unmasked).
REQ-016 A block-mode request SHALL get no memory access and an ACK with /TM1=1,/TM0=0 (error).
REQ-017 nub_startn asserted while not in IDLE SHALL be ignored.
REQ-018 The master path is not implemented: cpu_ready=0 and cpu_rdata=0, and no arbitration is performed.

Reset
REQ-019 While nub_reset=1 the block SHALL go to IDLE with all bus pins Z, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_slot=0, mem_super=0, cpu_ready=0.
REQ-020 A reset mid-cycle SHALL abort the cycle with no ACK.

Configuration
REQ-021 With NUBUS_SUPER_EN defined, A[31:28] = ~nub_idn with ~nub_idn in 1..E SHALL also be a hit and SHALL set mem_super=1; without it, super space SHALL be ignored and mem_super SHALL be tied to 0.

Verification
REQ-022 ID=0: write word F0000000 = 87654321 -> mem_write=1111, ACK complete; read word -> 87654321.
REQ-023 Write half0 F0000004 = 87654321 -> mem_write=0011; read half0 -> 00004321 (memory zeroed).
REQ-024 Write byte3 F0000018 = 87654321 -> mem_write=1000; read -> 87000000.
REQ-025 Access F1000000 with ID=0 -> no mem_valid, nub_ackn stays 1.
REQ-026 Memory wait of 3 clocks -> ACK exactly 1 clock after mem_ready; reset asserted during MEM -> no ACK, IDLE.
REQ-027 With NUBUS_SUPER_EN and ID=0x9, read 90000000 -> mem_super=1 and ACK; without the macro -> no response.
